// File: rtl/cla_seq_adder.sv
// Multi-cycle adder that reuses one 4-bit carry-lookahead slice, resolving
// one nibble per BUSY cycle and chaining the slice carry through a register.
module cla_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             busy,
    output logic             done
);

    localparam int SLICES = WIDTH / 4;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic [KW-1:0]    k_q;
    logic             co_q;
    logic             ov_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       aSlice;
    logic [3:0]       bSlice;
    logic [3:0]       gen;
    logic [3:0]       prop;
    logic [4:0]       carry_d;
    logic [3:0]       sumSlice_d;

    // Two-level lookahead: every carry is a flat sum of products of c0.
    always_comb begin
        aSlice     = a_q[{k_q, 2'b00} +: 4];
        bSlice     = b_q[{k_q, 2'b00} +: 4];
        gen        = aSlice & bSlice;
        prop       = aSlice | bSlice;
        carry_d[0] = c_q;
        carry_d[1] = gen[0] | (prop[0] & c_q);
        carry_d[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_q);
        carry_d[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                   | (prop[2] & prop[1] & prop[0] & c_q);
        carry_d[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                   | (prop[3] & prop[2] & prop[1] & gen[0])
                   | (prop[3] & prop[2] & prop[1] & prop[0] & c_q);
        sumSlice_d = aSlice ^ bSlice ^ carry_d[3:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= ci;
                        s_q     <= '0;
                        co_q    <= 1'b0;
                        ov_q    <= 1'b0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    s_q[{k_q, 2'b00} +: 4] <= sumSlice_d;
                    c_q <= carry_d[4];
                    k_q <= k_q + KW'(1);
                    // Overflow is the carry into the MSB against the carry out of it.
                    if (k_q == KW'(SLICES - 1)) begin
                        co_q    <= carry_d[4];
                        ov_q    <= carry_d[3] ^ carry_d[4];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: directed and random sums checked against a plain
// arithmetic model, plus handshake timing, back-to-back and reset cases.
module tb_cla_seq_adder;

    localparam int WIDTH  = 32;
    localparam int SLICES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             busy;
    logic             done;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .s       (s),
        .co      (co),
        .ov      (ov),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Hard stop in case something upstream stalls without tripping a bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference sum from integer arithmetic: returns {ov, co, s}.
    function automatic logic [WIDTH+1:0] refAdd(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic cin);
        logic [WIDTH:0] full;
        logic           ovf;
        full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
        ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {ovf, full};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents operands with start for one edge, then scrambles the inputs.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic opCi);
        a     = opA;
        b     = opB;
        ci    = opCi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ci    = 1'($urandom_range(0, 1));
    endtask

    // Full transaction: accept, wait bounded for done, check result and return to IDLE.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] opA,
                         input logic [WIDTH-1:0] opB, input logic opCi);
        logic [WIDTH+1:0] expv;
        int               lat;
        expv = refAdd(opA, opB, opCi);
        applyStimulus(opA, opB, opCi);
        checkOutput({tag, "_busy"}, 64'(busy), 64'(1));
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "_lat"}, 64'(lat), 64'(SLICES));
        checkOutput({tag, "_s"}, 64'(s), 64'(expv[WIDTH-1:0]));
        checkOutput({tag, "_co"}, 64'(co), 64'(expv[WIDTH]));
        checkOutput({tag, "_ov"}, 64'(ov), 64'(expv[WIDTH+1]));
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, 64'({busy, done}), 64'(0));
        checkOutput({tag, "_hold"}, 64'(s), 64'(expv[WIDTH-1:0]));
    endtask

    // Directed sequence: reset, plan vectors, random sums, timing, streaming, resets.
    initial begin
        logic [WIDTH+1:0] expv;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [63:0]      mask;
        int               seenDone;
        int               found;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        ci      = 1'b0;
        #12;
        checkOutput("rst_outputs", 64'({s, co, ov, busy, done}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_no_start", 64'({s, co, ov, busy, done}), 64'(0));

        runOp("ripple_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        runOp("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        runOp("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0);
        runOp("mixed_ci", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        runOp("zero_ci", 32'h0000_0000, 32'h0000_0000, 1'b1);

        for (int n = 0; n < 6; n++) begin
            runOp($sformatf("rand%0d", n), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        // Cycle-by-cycle handshake with the partial sum growing one nibble per edge.
        ra   = $urandom;
        rb   = $urandom;
        expv = refAdd(ra, rb, 1'b1);
        applyStimulus(ra, rb, 1'b1);
        checkOutput("tim_e0", 64'({busy, done}), 64'(2'b10));
        checkOutput("tim_s0", 64'(s), 64'(0));
        for (int j = 1; j < SLICES; j++) begin
            @(posedge clk);
            #1;
            mask = (64'(1) << (4 * j)) - 64'(1);
            checkOutput($sformatf("tim_e%0d", j), 64'({busy, done}), 64'(2'b10));
            checkOutput($sformatf("tim_s%0d", j), 64'(s), 64'(expv[WIDTH-1:0]) & mask);
        end
        @(posedge clk);
        #1;
        checkOutput("tim_done", 64'({busy, done}), 64'(2'b01));
        checkOutput("tim_sum", 64'(s), 64'(expv[WIDTH-1:0]));
        @(posedge clk);
        #1;
        checkOutput("tim_idle", 64'({busy, done}), 64'(2'b00));

        // start held high: busy x8, done x1, one IDLE cycle, repeat.
        ra    = $urandom;
        rb    = $urandom;
        expv  = refAdd(ra, rb, 1'b0);
        a     = ra;
        b     = rb;
        ci    = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3 * (SLICES + 2); i++) begin
            @(posedge clk);
            #1;
            if ((i % (SLICES + 2)) < SLICES)
                checkOutput($sformatf("b2b_c%0d", i), 64'({busy, done}), 64'(2'b10));
            else if ((i % (SLICES + 2)) == SLICES) begin
                checkOutput($sformatf("b2b_c%0d", i), 64'({busy, done}), 64'(2'b01));
                checkOutput($sformatf("b2b_s%0d", i), 64'({ov, co, s}), 64'(expv));
            end else
                checkOutput($sformatf("b2b_c%0d", i), 64'({busy, done}), 64'(2'b00));
        end
        start = 1'b0;

        // Abort mid-operation: outputs clear at once and no done follows.
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_clear", 64'({s, co, ov, busy, done}), 64'(0));
        @(negedge clk);
        reset_n  = 1'b1;
        seenDone = 0;
        for (int i = 0; i < 2 * SLICES; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seenDone++;
        end
        checkOutput("abort_no_done", 64'(seenDone), 64'(0));
        runOp("after_abort", 32'h0000_0003, 32'h0000_0004, 1'b0);

        // Reset while done is high drops it without waiting for an edge.
        applyStimulus($urandom, $urandom, 1'b0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1;
                break;
            end
        end
        checkOutput("done_seen", 64'(found), 64'(1));
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("done_rst", 64'({s, co, ov, busy, done}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        runOp("final", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
